// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: default register file geometry and
// architecturally special register numbers used by the register file and hazard unit.
package mips_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam int REG_ZERO = 0;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: storage select, same-cycle write forwarding
// and zero-register masking, producing the read data and its pending flag.
module regfile_rd_port
  import mips_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int DEPTH    = 1 << ADDR_W
) (
  input  logic                     active_i,
  input  logic [ADDR_W-1:0]        rd_addr_i,
  input  logic [DEPTH*DATA_W-1:0]  regs_i,
  input  logic [DEPTH-1:0]         pend_i,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     rd_pend_o
);

  always_comb begin
    rd_data_o = regs_i[rd_addr_i*DATA_W +: DATA_W];
    rd_pend_o = pend_i[rd_addr_i];
    // Ascending scan so the highest-index matching writer ends up forwarded.
    if (BYPASS != 0) begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en_i[j] && (wr_addr_i[j*ADDR_W +: ADDR_W] == rd_addr_i)) begin
          rd_data_o = wr_data_i[j*DATA_W +: DATA_W];
          rd_pend_o = 1'b0;
        end
      end
    end
    if ((ZERO_REG != 0) && (rd_addr_i == ADDR_W'(REG_ZERO))) begin
      rd_data_o = '0;
      rd_pend_o = 1'b0;
    end
    if (!active_i) begin
      rd_data_o = '0;
      rd_pend_o = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port MIPS register file with hardwired zero register, optional
// write-to-read bypass and a per-register pending scoreboard.
module regfile_mp
  import mips_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pend,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  output logic                     any_pend
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]       regs_q [DEPTH];
  logic [DATA_W-1:0]       regs_d [DEPTH];
  logic [DEPTH-1:0]        pend_q;
  logic [DEPTH-1:0]        pend_d;
  logic [DEPTH*DATA_W-1:0] regs_flat;

  function automatic logic isZeroReg(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == ADDR_W'(REG_ZERO));
  endfunction

  // Later ports overwrite earlier ones; alloc is applied last so a new producer wins.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j] && !isZeroReg(wr_addr[j*ADDR_W +: ADDR_W])) begin
        regs_d[wr_addr[j*ADDR_W +: ADDR_W]] = wr_data[j*DATA_W +: DATA_W];
        pend_d[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (alloc_en && !isZeroReg(alloc_addr)) begin
      pend_d[alloc_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q <= '{default: '0};
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  assign any_pend = rst & (|pend_q);

  for (genvar k = 0; k < DEPTH; k++) begin : g_flat
    assign regs_flat[k*DATA_W +: DATA_W] = regs_q[k];
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NUM_WR  (NUM_WR),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS),
      .DEPTH   (DEPTH)
    ) u_rd_port (
      .active_i (rst),
      .rd_addr_i(rd_addr[i*ADDR_W +: ADDR_W]),
      .regs_i   (regs_flat),
      .pend_i   (pend_q),
      .wr_en_i  (wr_en),
      .wr_addr_i(wr_addr),
      .wr_data_i(wr_data),
      .rd_data_o(rd_data[i*DATA_W +: DATA_W]),
      .rd_pend_o(rd_pend[i])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios followed by random
// traffic, compared against an array-based model of the register file.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic [1:0]  rd_pend;
  logic [1:0]  wr_en = '0;
  logic [9:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic        alloc_en = 1'b0;
  logic [4:0]  alloc_addr = '0;
  logic        any_pend;

  int checks = 0;
  int errors = 0;

  logic [31:0] modelRegs [32];
  bit          modelPend [32];

  regfile_mp dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_pend   (rd_pend),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .alloc_en  (alloc_en),
    .alloc_addr(alloc_addr),
    .any_pend  (any_pend)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    for (int r = 0; r < 32; r++) begin
      modelRegs[r] = '0;
      modelPend[r] = 1'b0;
    end
  endtask

  // Architectural effect of one clock edge: writes land (last port wins),
  // writes retire their producer, then a fresh alloc marks the register.
  task automatic modelClock();
    int a;
    if (rst) begin
      for (int j = 0; j < 2; j++) begin
        a = int'(wr_addr[j*5 +: 5]);
        if (wr_en[j] && a != 0) begin
          modelRegs[a] = wr_data[j*32 +: 32];
          modelPend[a] = 1'b0;
        end
      end
      if (alloc_en && alloc_addr != 5'd0) modelPend[int'(alloc_addr)] = 1'b1;
    end
  endtask

  task automatic expRead(input int a, output logic [31:0] d, output logic p);
    d = modelRegs[a];
    p = modelPend[a];
    for (int j = 0; j < 2; j++) begin
      if (wr_en[j] && int'(wr_addr[j*5 +: 5]) == a) begin
        d = wr_data[j*32 +: 32];
        p = 1'b0;
      end
    end
    if (a == 0 || !rst) begin
      d = '0;
      p = 1'b0;
    end
  endtask

  function automatic logic expAnyPend();
    logic r = 1'b0;
    for (int k = 0; k < 32; k++) r = r | modelPend[k];
    return r & rst;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    logic [31:0] d;
    logic        p;
    for (int i = 0; i < 2; i++) begin
      expRead(int'(rd_addr[i*5 +: 5]), d, p);
      checkOutput($sformatf("%s_data%0d", tag, i), rd_data[i*32 +: 32], d);
      checkOutput($sformatf("%s_pend%0d", tag, i), {31'd0, rd_pend[i]}, {31'd0, p});
    end
    checkOutput($sformatf("%s_anypend", tag), {31'd0, any_pend}, {31'd0, expAnyPend()});
  endtask

  task automatic applyStimulus(input logic [1:0] en,
                               input logic [4:0] wa0, input logic [31:0] wd0,
                               input logic [4:0] wa1, input logic [31:0] wd1,
                               input logic [4:0] ra0, input logic [4:0] ra1,
                               input logic ae, input logic [4:0] aa);
    wr_en      = en;
    wr_addr    = {wa1, wa0};
    wr_data    = {wd1, wd0};
    rd_addr    = {ra1, ra0};
    alloc_en   = ae;
    alloc_addr = aa;
  endtask

  task automatic tick();
    @(posedge clk);
    modelClock();
    #1;
  endtask

  initial begin
    modelReset();

    // Reset held: writes and alloc on every port must stay invisible.
    applyStimulus(2'b11, 5'd10, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, 5'd10, 5'd4, 1'b1, 5'd7);
    #1 checkAll("rst_hold_a");
    tick();
    checkAll("rst_hold_b");
    tick();
    checkAll("rst_hold_c");
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd10, 5'd4, 1'b0, 5'd0);
    #1 rst = 1'b1;
    #1 checkAll("rst_release");
    tick();

    // Basic write/read with bypass.
    applyStimulus(2'b01, 5'd10, 32'd9, 5'd0, 32'd0, 5'd10, 5'd4, 1'b0, 5'd0);
    #1 checkAll("wr_r10_bypass");
    tick();
    applyStimulus(2'b01, 5'd4, 32'd18, 5'd0, 32'd0, 5'd10, 5'd4, 1'b0, 5'd0);
    #1 checkAll("wr_r4_bypass");
    tick();
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd10, 5'd4, 1'b0, 5'd0);
    #1 checkAll("rd_r10_r4");
    checkOutput("r10_direct", rd_data[31:0], 32'd9);
    checkOutput("r4_direct", rd_data[63:32], 32'd18);

    // Dual-write conflict: port 1 wins.
    applyStimulus(2'b11, 5'd8, 32'd36, 5'd8, 32'd72, 5'd8, 5'd8, 1'b0, 5'd0);
    #1 checkAll("dual_wr_bypass");
    checkOutput("dual_wr_bypass_const", rd_data[31:0], 32'd72);
    tick();
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd8, 5'd8, 1'b0, 5'd0);
    #1 checkAll("dual_wr_stored");
    checkOutput("dual_wr_stored_const", rd_data[63:32], 32'd72);

    // Zero register ignores writes and alloc.
    applyStimulus(2'b11, 5'd0, 32'd5, 5'd0, 32'd5, 5'd0, 5'd0, 1'b1, 5'd0);
    #1 checkAll("zero_wr");
    tick();
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0);
    #1 checkAll("zero_after");
    checkOutput("zero_anypend_const", {31'd0, any_pend}, 32'd0);

    // Scoreboard: alloc, retire with bypass, then alloc+write collision.
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd7, 5'd10, 1'b1, 5'd7);
    #1 checkAll("alloc_r7_same");
    tick();
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd7, 5'd10, 1'b0, 5'd0);
    #1 checkAll("alloc_r7_next");
    checkOutput("r7_pend_const", {31'd0, rd_pend[0]}, 32'd1);
    applyStimulus(2'b01, 5'd7, 32'd3, 5'd0, 32'd0, 5'd7, 5'd10, 1'b0, 5'd0);
    #1 checkAll("wr_r7_bypass");
    tick();
    applyStimulus(2'b01, 5'd7, 32'd11, 5'd0, 32'd0, 5'd7, 5'd10, 1'b1, 5'd7);
    #1 checkAll("alloc_wr_r7");
    tick();
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd7, 5'd10, 1'b0, 5'd0);
    #1 checkAll("alloc_wins");
    checkOutput("alloc_wins_const", {31'd0, rd_pend[0]}, 32'd1);

    // Asynchronous reset between edges, with a write attempted while held.
    #2 rst = 1'b0;
    modelReset();
    #1 checkAll("async_rst_now");
    applyStimulus(2'b01, 5'd10, 32'd55, 5'd0, 32'd0, 5'd10, 5'd7, 1'b1, 5'd12);
    tick();
    checkAll("async_rst_held");
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd10, 5'd12, 1'b0, 5'd0);
    #1 rst = 1'b1;
    #1 checkAll("async_rst_release");
    checkOutput("r10_cleared_const", rd_data[31:0], 32'd0);
    tick();

    // Random traffic on a narrow address range to force collisions.
    for (int n = 0; n < 300; n++) begin
      applyStimulus(2'($urandom_range(0, 3)),
                    5'($urandom_range(0, 7)), $urandom,
                    5'($urandom_range(0, 7)), $urandom,
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                    ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)));
      #1 checkAll("rand");
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
